// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types, constants and helpers for the RC4 key-scheduling and PRGA stages
package rc4_pkg;
  localparam int MSG_LEN_DEF = 32;
  localparam logic [7:0] CHAR_LO = 8'h61;
  localparam logic [7:0] CHAR_HI = 8'h7A;
  localparam logic [7:0] CHAR_SP = 8'h20;
  typedef enum logic [1:0] {KSA_IDLE, KSA_INIT, KSA_SHUFFLE, KSA_DONE} ksa_mode_t;
  typedef enum logic [3:0] {
    IDLE, RD_I, WT_I, LT_I, WT_J, LT_J, WR_J, RD_F, WT_F, WR_D, DONE
  } prga_state_t;
  function automatic logic is_legal_char(input logic [7:0] b);
    return (b >= CHAR_LO && b <= CHAR_HI) || b == CHAR_SP;
  endfunction
endpackage

// File: rtl/prga_decrypt.sv
// prga_decrypt: RC4 PRGA walk over S RAM, XOR with encrypted ROM, plaintext to decrypted RAM
//   clk/reset_n        : clock, asynchronous active-low reset
//   start/busy/done    : one-cycle start pulse, run status
//   valid              : all written plaintext bytes are a..z or space (meaningful while done)
//   s_address/s_data/s_wren/s_q          : S RAM port (1-cycle read latency)
//   rom_address/rom_q                    : encrypted message ROM (1-cycle read latency)
//   d_address/d_data/d_wren              : decrypted message RAM write port
//   PRGA_EARLY_ABORT_EN : when defined, the first illegal plaintext byte ends the run
module prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEF,
  parameter int MSG_AW  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [MSG_AW-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic [MSG_AW-1:0] d_address,
  output logic [7:0]        d_data,
  output logic              d_wren
);
  prga_state_t state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [MSG_AW-1:0] k_q, k_d;
  logic busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic [7:0] s_address_q, s_address_d, s_data_q, s_data_d;
  logic s_wren_q, s_wren_d, d_wren_q, d_wren_d;
  logic [MSG_AW-1:0] rom_address_q, rom_address_d, d_address_q, d_address_d;
  logic [7:0] d_data_q, d_data_d;
  logic [7:0] plain;
  logic legal, last_byte, stop;
  assign plain     = s_q ^ rom_q;
  assign legal     = is_legal_char(plain);
  assign last_byte = k_q == MSG_AW'(MSG_LEN - 1);
`ifdef PRGA_EARLY_ABORT_EN
  assign stop = last_byte || !legal;
`else
  assign stop = last_byte;
`endif
  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    si_d          = si_q;
    sj_d          = sj_q;
    busy_d        = busy_q;
    done_d        = done_q;
    valid_d       = valid_q;
    s_address_d   = s_address_q;
    s_data_d      = s_data_q;
    s_wren_d      = 1'b0;
    rom_address_d = rom_address_q;
    d_address_d   = d_address_q;
    d_data_d      = d_data_q;
    d_wren_d      = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        done_d  = 1'b0;
        valid_d = 1'b1;
        busy_d  = 1'b1;
        state_d = RD_I;
      end
      RD_I: begin
        i_d         = i_q + 8'd1;
        s_address_d = i_q + 8'd1;
        state_d     = WT_I;
      end
      WT_I: state_d = LT_I;
      LT_I: begin
        si_d        = s_q;
        j_d         = j_q + s_q;
        s_address_d = j_q + s_q;
        state_d     = WT_J;
      end
      WT_J: begin
        rom_address_d = k_q;
        state_d       = LT_J;
      end
      // S[j] arrives this cycle, so it is written to S[i] straight from s_q
      LT_J: begin
        sj_d        = s_q;
        s_address_d = i_q;
        s_data_d    = s_q;
        s_wren_d    = 1'b1;
        state_d     = WR_J;
      end
      WR_J: begin
        s_address_d = j_q;
        s_data_d    = si_q;
        s_wren_d    = 1'b1;
        state_d     = RD_F;
      end
      RD_F: begin
        s_address_d = si_q + sj_q;
        state_d     = WT_F;
      end
      WT_F: state_d = WR_D;
      WR_D: begin
        d_address_d = k_q;
        d_data_d    = plain;
        d_wren_d    = 1'b1;
        valid_d     = valid_q & legal;
        k_d         = stop ? k_q : k_q + 1'b1;
        busy_d      = !stop;
        done_d      = stop;
        state_d     = stop ? DONE : RD_I;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      i_q           <= '0;
      j_q           <= '0;
      k_q           <= '0;
      si_q          <= '0;
      sj_q          <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      valid_q       <= 1'b1;
      s_address_q   <= '0;
      s_data_q      <= '0;
      s_wren_q      <= 1'b0;
      rom_address_q <= '0;
      d_address_q   <= '0;
      d_data_q      <= '0;
      d_wren_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      k_q           <= k_d;
      si_q          <= si_d;
      sj_q          <= sj_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      valid_q       <= valid_d;
      s_address_q   <= s_address_d;
      s_data_q      <= s_data_d;
      s_wren_q      <= s_wren_d;
      rom_address_q <= rom_address_d;
      d_address_q   <= d_address_d;
      d_data_q      <= d_data_d;
      d_wren_q      <= d_wren_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign valid       = valid_q;
  assign s_address   = s_address_q;
  assign s_data      = s_data_q;
  assign s_wren      = s_wren_q;
  assign rom_address = rom_address_q;
  assign d_address   = d_address_q;
  assign d_data      = d_data_q;
  assign d_wren      = d_wren_q;
endmodule

// File: tb/tb_prga_decrypt.sv
// tb_prga_decrypt: table-driven and randomized check of prga_decrypt against a software RC4 model
module tb_prga_decrypt;
  localparam int MSG_LEN = 32;
  localparam int MSG_AW  = 5;
`ifdef PRGA_EARLY_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif
  localparam logic [7:0] SENT = 8'hEE;
  logic clk, reset_n, start, busy, done, valid, s_wren, d_wren;
  logic [7:0] s_address, s_data, s_q, rom_q, d_data;
  logic [MSG_AW-1:0] rom_address, d_address;
  logic [7:0] smem [256];
  logic [7:0] s_init [256];
  logic [7:0] rom [MSG_LEN];
  logic [7:0] dmem [MSG_LEN];
  logic load_s, load_d;
  logic [7:0] m_s [256];
  logic [7:0] m_d [MSG_LEN];
  logic [7:0] m_ks [MSG_LEN];
  logic m_valid;
  int m_n;
  int total = 0, bad = 0;
  int nsw, ndw, nov;
  logic [7:0] snap2, snap3;
  prga_decrypt #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .valid(valid),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .rom_address(rom_address), .rom_q(rom_q),
    .d_address(d_address), .d_data(d_data), .d_wren(d_wren)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (load_s) for (int a = 0; a < 256; a++) smem[a] <= s_init[a];
    else if (s_wren) smem[s_address] <= s_data;
    if (load_d) for (int a = 0; a < MSG_LEN; a++) dmem[a] <= SENT;
    else if (d_wren) dmem[d_address] <= d_data;
    s_q   <= smem[s_address];
    rom_q <= rom[rom_address];
  end
  function automatic bit legal(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7a) || b == 8'h20;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  // plain RC4 PRGA from i=j=0 over m_s, in place
  task automatic rc4(input bit ab);
    int i = 0, j = 0;
    logic [7:0] t;
    m_valid = 1'b1;
    m_n = 0;
    for (int n = 0; n < MSG_LEN; n++) m_d[n] = SENT;
    for (int n = 0; n < MSG_LEN; n++) begin
      i = (i + 1) % 256;
      j = (j + m_s[i]) % 256;
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      m_ks[n] = m_s[(m_s[i] + m_s[j]) % 256];
      m_d[n] = m_ks[n] ^ rom[n];
      m_n = n + 1;
      if (!legal(m_d[n])) begin
        m_valid = 1'b0;
        if (ab) break;
      end
    end
  endtask
  // s_mode: 0 identity, 1 random permutation, 2 keep current RAM
  // rom_mode: 0 zeros, 1 "cd" then zeros, 2 plaintext encrypted, 3 same with byte 7 = 0x00, 4 random
  task automatic setup(input int sm, input int rm);
    string pt = "attack at dawn and hold the line";
    if (sm != 2) for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    if (sm == 1)
      for (int a = 255; a > 0; a--) begin
        int b;
        logic [7:0] t;
        b = $urandom_range(a, 0);
        t = s_init[a]; s_init[a] = s_init[b]; s_init[b] = t;
      end
    @(negedge clk);
    load_s = (sm != 2);
    load_d = 1'b1;
    @(negedge clk);
    load_s = 1'b0;
    load_d = 1'b0;
    for (int a = 0; a < 256; a++) m_s[a] = smem[a];
    if (rm == 2 || rm == 3) begin
      rc4(1'b0);
      for (int a = 0; a < 256; a++) m_s[a] = smem[a];
    end
    for (int n = 0; n < MSG_LEN; n++)
      rom[n] = rm == 4 ? 8'($urandom) : (rm == 2 || rm == 3) ? m_ks[n] ^ pt[n] : 8'h00;
    if (rm == 1) begin rom[0] = 8'h63; rom[1] = 8'h64; end
    if (rm == 3) rom[7] = m_ks[7];
    rc4(ABORT);
  endtask
  task automatic tally(input int cyc);
    if (s_wren) nsw++;
    if (d_wren) ndw++;
    if (s_wren && d_wren) nov++;
    if (cyc == 18) begin snap2 = smem[2]; snap3 = smem[3]; end
  endtask
  task automatic do_run(input string tag, input int poke, output int cyc);
    nsw = 0; ndw = 0; nov = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk({tag, "_busy_on_start"}, busy, 1);
    chk({tag, "_done_on_start"}, done, 0);
    tally(cyc);
    while (!done && cyc < 9 * MSG_LEN + 40) begin
      @(negedge clk);
      cyc++;
      start = cyc == poke;
      tally(cyc);
    end
    start = 1'b0;
    @(negedge clk);
    tally(cyc + 1);
  endtask
  task automatic check_result(input string tag, input int cyc);
    int nm = 0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cycles"}, cyc, 9 * m_n + 1);
    chk({tag, "_valid"}, valid, m_valid);
    chk({tag, "_wren_idle"}, {s_wren, d_wren}, 0);
    chk({tag, "_wren_overlap"}, nov, 0);
    chk({tag, "_s_writes"}, nsw, 2 * m_n);
    chk({tag, "_d_writes"}, ndw, m_n);
    for (int n = 0; n < MSG_LEN; n++) chk($sformatf("%s_d%0d", tag, n), dmem[n], m_d[n]);
    for (int a = 0; a < 256; a++) if (smem[a] !== m_s[a]) nm++;
    chk({tag, "_s_ram_mismatches"}, nm, 0);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, valid, 1);
    chk({tag, "_s_wren"}, s_wren, 0);
    chk({tag, "_d_wren"}, d_wren, 0);
    chk({tag, "_s_address"}, s_address, 0);
    chk({tag, "_s_data"}, s_data, 0);
    chk({tag, "_rom_address"}, rom_address, 0);
    chk({tag, "_d_address"}, d_address, 0);
    chk({tag, "_d_data"}, d_data, 0);
  endtask
  typedef struct packed {
    int s_mode; int rom_mode; int poke; int d0; int d1; int s2; int s3; int vld;
  } vec_t;
  vec_t tbl [6];
  initial begin
    int cyc;
    tbl[0] = '{0, 0, -1, 32'h02, ABORT ? -1 : 32'h05, -1, -1, 0};
    tbl[1] = '{0, 1, -1, 32'h61, 32'h61, 32'h03, 32'h02, -1};
    tbl[2] = '{0, 2, 100, -1, -1, -1, -1, 1};
    tbl[3] = '{0, 3, -1, -1, -1, -1, -1, 0};
    tbl[4] = '{1, 4, -1, -1, -1, -1, -1, -1};
    tbl[5] = '{2, 4, -1, -1, -1, -1, -1, -1};
    reset_n = 1'b0;
    start = 1'b0;
    load_s = 1'b0;
    load_d = 1'b0;
    for (int n = 0; n < MSG_LEN; n++) rom[n] = 8'h00;
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    #22;
    chk_reset("por");
    @(negedge clk);
    reset_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      string tag;
      tag = $sformatf("v%0d", t);
      setup(tbl[t].s_mode, tbl[t].rom_mode);
      do_run(tag, tbl[t].poke, cyc);
      check_result(tag, cyc);
      if (tbl[t].d0 >= 0) chk({tag, "_const_d0"}, dmem[0], tbl[t].d0);
      if (tbl[t].d1 >= 0) chk({tag, "_const_d1"}, dmem[1], tbl[t].d1);
      if (tbl[t].s2 >= 0) chk({tag, "_s2_after_byte1"}, snap2, tbl[t].s2);
      if (tbl[t].s3 >= 0) chk({tag, "_s3_after_byte1"}, snap3, tbl[t].s3);
      if (tbl[t].vld >= 0) chk({tag, "_const_valid"}, valid, tbl[t].vld);
      if (t == 3) chk({tag, "_cycles_const"}, cyc, ABORT ? 9 * 8 + 1 : 9 * MSG_LEN + 1);
    end
    setup(0, 2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset("midrst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    setup(0, 2);
    do_run("restart", -1, cyc);
    check_result("restart", cyc);
    chk("restart_const_valid", valid, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prga_decrypt.md
Name: prga_decrypt

Overview:
RC4 pseudo-random generation and decrypt stage, directly downstream of the key-scheduling stage. Once S RAM holds the shuffled permutation, this block walks the PRGA over MSG_LEN bytes and swaps S entries in place. It XORs each keystream byte with the encrypted-message ROM and writes plaintext to the decrypted RAM. It also flags whether every plaintext byte is a legal character, which feeds the key-search controller.

Parameters:
- MSG_LEN, 32, message length in bytes; power of two, ≤ 256.
- MSG_AW, 5, address width of the ROM and decrypted RAM; equals log2(MSG_LEN).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse from the top FSM; accepted only in IDLE or DONE.
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- done  out  1  high in DONE; holds until the next accepted start or reset.
- valid  out  1  meaningful while done=1: every written byte is 0x61..0x7A or 0x20.
- s_address  out  8  S RAM address.
- s_data  out  8  S RAM write data.
- s_wren  out  1  S RAM write enable.
- s_q  in  8  S RAM read data; synchronous, 1-cycle latency.
- rom_address  out  MSG_AW  encrypted ROM address.
- rom_q  in  8  ROM data; 1-cycle latency.
- d_address  out  MSG_AW  decrypted RAM address.
- d_data  out  8  decrypted RAM write data.
- d_wren  out  1  decrypted RAM write enable.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state=IDLE; i, j, k, si, sj = 0; valid=1; busy, done, s_wren, d_wren = 0; all addresses and data = 0.
- All outputs are registered. RAM read data is sampled exactly one cycle after its address is presented.
- Arithmetic: i, j, si+sj are 8-bit and wrap mod 256. k counts 0..MSG_LEN-1.
- start handling: accepted in IDLE or DONE. On acceptance, clear i, j, k, done; set valid=1; go to RD_I.
- start is ignored in every other state.
- Per-byte states, 9 cycles per byte, 9*MSG_LEN+1 cycles from start to done:
  - RD_I: i←i+1; s_address=i+1.
  - WT_I: wait one cycle for read latency.
  - LT_I: si←s_q; j←j+s_q; s_address=j+s_q.
  - WT_J: wait; rom_address=k.
  - LT_J: sj←s_q; s_address=i; s_data=sj; s_wren=1.
  - WR_J: s_address=j; s_data=si; s_wren=1.
  - RD_F: s_wren=0; s_address=si+sj.
  - WT_F: wait.
  - WR_D: d_address=k; d_data=s_q^rom_q; d_wren=1; if that byte is illegal, valid←0.
  - After WR_D: if k=MSG_LEN-1 go to DONE, else k←k+1 and go to RD_I.
- i=j aliasing: when i=j, both swap writes hit the same address with the same value; no special case is needed. The result must equal the software model.
- The ROM read is issued in WT_J so rom_q is stable through WR_D.
- DONE: busy=0, done=1, all write enables 0. Final S contents remain in RAM.
- Reset mid-operation: immediate return to reset values. Partially written RAMs are not restored.
- Write enables are high for exactly one cycle per write. s_wren and d_wren are never high together.

Optional Feature:
- Macro: PRGA_EARLY_ABORT_EN.
- Defined: in WR_D, an illegal byte is still written, then the block goes straight to DONE with valid=0. This shortens key-search iterations.
- Undefined: all MSG_LEN bytes are always processed, and valid is the AND over all bytes.

Decomposition:
- Shared package rc4_pkg holds:
  - prga_state_t enum.
  - MSG_LEN_DEF constant.
  - CHAR_LO=0x61, CHAR_HI=0x7A, CHAR_SP=0x20.
  - Function is_legal_char(byte).
- Also place the key-scheduling mode enum in rc4_pkg so both stages share it.
- No sub-module; one FSM plus datapath registers is natural.

Test Plan:
- Identity S (S[x]=x), ROM all 0x00 → d[0]=0x02, d[1]=0x05; valid=0; done high 9*32+1 cycles after start.
- Identity S, rom[0]=0x63, rom[1]=0x64 → d[0]=0x61, d[1]=0x61.
- Identity S, after the run: S[2]=0x03, S[3]=0x02 (byte-1 swap); compare the full S and all 32 d bytes against a C RC4 model.
- ROM = model keystream XOR "attack at dawn..." (legal characters) → valid=1. Flip byte 7 to 0x00 → valid=0. With PRGA_EARLY_ABORT_EN, done rises after the byte-7 write and d[8..31] are untouched.
- Drop reset_n during byte 3 → all outputs return to reset values asynchronously; a restart reproduces the full correct result.
- Pulse start while busy → ignored, no restart. Pulse start in DONE → done drops, second run proceeds on the already-permuted S and matches the model.
